// File: rtl/uart_tx_fsm_if.sv
// Host-side transmit bus of uart_tx_fsm: word handshake plus serial line and status.
// Handshake: a word moves on a rising clk edge where tx_valid && tx_ready. Once it
// raises tx_valid, the master holds tx_valid and tx_data stable until that edge.
// tx_ready never depends combinationally on tx_valid.
interface uart_tx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_line;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_line,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_line,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start(0), DATA_BITS data bits LSB first, one parity bit, stop(1).
// Define TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_fsm #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_fsm_if.slave txIf,
  output logic [2:0]   dbgState
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txStateT;

  txStateT              state, stateNext;
  logic [CW-1:0]        clkCnt, clkCntNext;
  logic [IW-1:0]        bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic                 parityReg, parityNext;
  logic                 lineReg, lineNext;
  logic                 accept;
  logic                 bitEnd;
  logic                 lastStop;

`ifdef TX_TWO_STOP_EN
  // Marks the second of the two stop bits.
  logic stopIdx, stopIdxNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stopIdx <= 1'b0;
    end else begin
      stopIdx <= stopIdxNext;
    end
  end

  always_comb begin
    stopIdxNext = stopIdx;
    if (state == PARITY) begin
      stopIdxNext = 1'b0;
    end else if (state == STOP && bitEnd && !stopIdx) begin
      stopIdxNext = 1'b1;
    end
  end

  assign lastStop = stopIdx;
`else
  assign lastStop = 1'b1;
`endif

  assign accept = txIf.tx_valid && (state == IDLE);
  assign bitEnd = (clkCnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clkCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityReg <= 1'b0;
      lineReg   <= 1'b1;
    end else begin
      state     <= stateNext;
      clkCnt    <= clkCntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      parityReg <= parityNext;
      lineReg   <= lineNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clkCntNext = clkCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    parityNext = parityReg;
    lineNext   = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext  = START;
          clkCntNext = '0;
          bitIdxNext = '0;
          shiftNext  = txIf.tx_data;
          parityNext = (^txIf.tx_data) ^ ODD_PAR;
        end
      end

      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          clkCntNext = '0;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end

      DATA: begin
        if (bitEnd) begin
          clkCntNext = '0;
          shiftNext  = shiftReg >> 1;
          if (bitIdx == LAST_IDX) begin
            stateNext  = PARITY;
            bitIdxNext = '0;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end

      PARITY: begin
        if (bitEnd) begin
          stateNext  = STOP;
          clkCntNext = '0;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end

      STOP: begin
        if (bitEnd) begin
          clkCntNext = '0;
          if (lastStop) begin
            stateNext = IDLE;
          end
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end

      default: begin
        stateNext  = IDLE;
        clkCntNext = '0;
        bitIdxNext = '0;
      end
    endcase

    // The line is registered from the upcoming state so every bit starts on a clean edge.
    case (stateNext)
      START:   lineNext = 1'b0;
      DATA:    lineNext = shiftNext[0];
      PARITY:  lineNext = parityNext;
      default: lineNext = 1'b1;
    endcase
  end

  assign txIf.tx_line  = lineReg;
  assign txIf.tx_ready = (state == IDLE);
  assign txIf.tx_busy  = (state != IDLE);
  assign txIf.tx_done  = (state == STOP) && bitEnd && lastStop;
  assign dbgState      = state;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: an even- and an odd-parity instance share one stimulus stream
// and are compared cycle by cycle against frames built from the UART framing rules.
module tb_uart_tx_fsm;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int FRAME = (DB + 2 + STOPS) * CPB;
  localparam int W     = 4;
  localparam logic [W-1:0] IDLE_OBS = 4'b1010;  // {line, busy, ready, done}

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] txData;
  logic          txValid;
  logic [2:0]    dbgEven, dbgOdd;
  int            checks = 0;
  int            errors = 0;

  logic [W-1:0] expEvenQ[$];
  logic [W-1:0] expOddQ[$];

  uart_tx_fsm_if #(.DATA_BITS(DB)) ifEven ();
  uart_tx_fsm_if #(.DATA_BITS(DB)) ifOdd ();

  assign ifEven.tx_data  = txData;
  assign ifEven.tx_valid = txValid;
  assign ifOdd.tx_data   = txData;
  assign ifOdd.tx_valid  = txValid;

  always #5 clk = ~clk;

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dutEven (
    .clk      (clk),
    .reset    (reset),
    .txIf     (ifEven),
    .dbgState (dbgEven)
  );

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(1)) dutOdd (
    .clk      (clk),
    .reset    (reset),
    .txIf     (ifOdd),
    .dbgState (dbgOdd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial value k cycles into a frame: slot 0 start, 1..DB data, then parity, then stop.
  function automatic logic exp_line(input logic [DB-1:0] d, input bit odd, input int k);
    int slot;
    int ones;
    slot = k / CPB;
    ones = $countones(d);
    if (slot == 0) return 1'b0;
    if (slot <= DB) return d[slot-1];
    if (slot == DB + 1) return ((ones % 2) == 1) ^ odd;
    return 1'b1;
  endfunction

  task automatic load_frame(input logic [DB-1:0] d);
    for (int k = 0; k < FRAME; k++) begin
      expEvenQ.push_back({exp_line(d, 1'b0, k), 1'b1, 1'b0, (k == FRAME - 1)});
      expOddQ.push_back({exp_line(d, 1'b1, k), 1'b1, 1'b0, (k == FRAME - 1)});
    end
  endtask

  function automatic logic [W-1:0] obs_even();
    return {ifEven.tx_line, ifEven.tx_busy, ifEven.tx_ready, ifEven.tx_done};
  endfunction

  function automatic logic [W-1:0] obs_odd();
    return {ifOdd.tx_line, ifOdd.tx_busy, ifOdd.tx_ready, ifOdd.tx_done};
  endfunction

  task automatic check_cycle();
    logic [W-1:0] e;
    logic [W-1:0] o;
    e = expEvenQ.pop_front();
    o = expOddQ.pop_front();
    check("even_frame", 32'(obs_even()), 32'(e));
    check("odd_frame", 32'(obs_odd()), 32'(o));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_even"}, 32'(obs_even()), 32'(IDLE_OBS));
    check({tag, "_odd"}, 32'(obs_odd()), 32'(IDLE_OBS));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(ifEven.tx_ready && ifOdd.tx_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 100), 32'd1);
  endtask

  // Offers d, lets it be accepted, then changes tx_data/tx_valid mid-frame.
  task automatic run_frame(input logic [DB-1:0] d, input bit keepValid,
                           input logic [DB-1:0] midData);
    txData  = d;
    txValid = 1'b1;
    wait_ready();
    load_frame(d);
    @(posedge clk);
    @(negedge clk);
    txData  = midData;
    txValid = keepValid;
    for (int k = 0; k < FRAME; k++) begin
      check_cycle();
      @(negedge clk);
    end
    check_idle("gap_idle");
  endtask

  initial begin
    reset   = 1'b0;
    txValid = 1'b0;
    txData  = '0;

    repeat (3) begin
      @(negedge clk);
      check_idle("reset_held");
    end
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check_idle("idle_no_valid");
    end

    run_frame(8'hA5, 1'b0, 8'h00);
    run_frame(8'h01, 1'b0, 8'hFE);
    run_frame(8'h00, 1'b0, 8'hFF);

    run_frame(8'h55, 1'b1, 8'h0F);
    run_frame(8'h0F, 1'b0, 8'hAA);

    // Abort a frame while data bits are on the line.
    txData  = 8'($urandom_range(0, 255));
    txValid = 1'b1;
    wait_ready();
    load_frame(txData);
    @(posedge clk);
    @(negedge clk);
    txValid = 1'b0;
    for (int k = 0; k < 3 * CPB; k++) begin
      check_cycle();
      @(negedge clk);
    end
    #1 reset = 1'b0;
    #1 check_idle("async_reset");
    expEvenQ.delete();
    expOddQ.delete();
    repeat (3) begin
      @(negedge clk);
      check_idle("reset_mid_held");
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("post_abort");
    end
    run_frame(8'h3C, 1'b0, 8'($urandom_range(0, 255)));

    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
    end

    run_frame(8'hFF, 1'b0, 8'h00);
    repeat (4) begin
      @(negedge clk);
      check_idle("final_idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
